// File: rtl/and_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : and_arb_pkg
//  Description : Shared types and constants for the AND datapath arbiter.
//                Contents:
//                  - arb_state_t : FSM state encoding (IDLE, RESP)
//                  - CNT_W       : width of the accepted-operation counter
//                  - id_width()  : requester-ID width, never below 1 bit
//  Revision    : 1.0 - initial release
// ============================================================================
package and_arb_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  // A lone requester still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : and_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. The request vector is
//                rotated so that requester last+1 sits at bit 0. The lowest
//                set bit of the rotated vector wins. Its offset is then
//                rotated back into an absolute requester index.
//  Ports       : req    - request vector
//                last   - index of the most recent winner
//                en     - allows a grant to be driven
//                gnt    - one-hot grant (all zero when !en or no request)
//                gnt_id - winner index (valid whenever any = 1)
//                any    - at least one request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import and_arb_pkg::*;
#(
  parameter  int N    = 2,
  localparam int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  localparam logic [ID_W:0]   C_N        = (ID_W+1)'(N);
  localparam logic [ID_W-1:0] C_LAST_IDX = ID_W'(N-1);

  logic [ID_W-1:0] w_start;
  logic [2*N-1:0]  w_dbl;
  logic [N-1:0]    w_rot;
  logic [ID_W-1:0] w_ofs;
  logic [ID_W:0]   w_sum;
  logic            w_hit;

  always_comb begin
    // Priority starts just after the previous winner, wrapping at N.
    w_start = (last >= C_LAST_IDX) ? '0 : last + ID_W'(1);
    // Shifting a doubled copy of the vector implements a rotate-right.
    w_dbl   = {req, req} >> w_start;
    w_rot   = w_dbl[N-1:0];

    w_hit = 1'b0;
    w_ofs = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_hit = 1'b1;
        w_ofs = ID_W'(i);
      end
    end

    // Rotate back. Both terms are below N, so one conditional subtract
    // completes the modulo.
    w_sum = {1'b0, w_ofs} + {1'b0, w_start};
    if (w_sum >= C_N) begin
      w_sum = w_sum - C_N;
    end

    gnt_id = w_sum[ID_W-1:0];
    any    = w_hit;
    gnt    = '0;
    if (en && w_hit) begin
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/and_datapath_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : and_datapath_arbiter
//  Description : Shares a single registered bitwise-AND stage among N_REQ
//                requesters. The block uses round-robin grant and returns a
//                1-cycle-latency result under a backpressured response
//                handshake.
//  Ports       : clk, rst_n         - clock, async active-low reset
//                req_valid/req_ready - per-requester operand handshake
//                req_a, req_b        - per-requester operands
//                rsp_valid/rsp_ready - result handshake
//                rsp_id, rsp_q       - winner ID and registered a & b
//                op_count            - saturating accepted-operation count
//  Revision    : 1.0 - initial release
// ============================================================================
module and_datapath_arbiter
  import and_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int WIDTH = 8,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [WIDTH-1:0]            rsp_q,
  output logic [CNT_W-1:0]            op_count
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_q;
  logic [CNT_W-1:0] r_op_count;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_en;
  logic             w_any;
  logic             w_accept;

  // A grant is allowed in IDLE, or in RESP once the held result is consumed.
  // The term rst_n keeps req_ready low for the whole reset.
  assign w_en     = rst_n && ((r_state == IDLE) || rsp_ready);
  assign w_accept = w_en && w_any;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req    (req_valid),
    .last   (r_last),
    .en     (w_en),
    .gnt    (req_ready),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = RESP;
      RESP: if (rsp_ready && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= ID_W'(N_REQ-1);
      r_rsp_id   <= '0;
      r_rsp_q    <= '0;
      r_op_count <= '0;
    end else if (w_accept) begin
      r_last   <= w_gnt_id;
      r_rsp_id <= w_gnt_id;
      r_rsp_q  <= req_a[w_gnt_id] & req_b[w_gnt_id];
      if (r_op_count != {CNT_W{1'b1}}) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign op_count  = r_op_count;

endmodule : and_datapath_arbiter
`default_nettype wire

// File: doc/and_datapath_arbiter.md
# and_datapath_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise-AND datapath among `N_REQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester per cycle, registers `a & b`, and returns the result with the winner's ID under a backpressured response handshake. It sits between the requester logic and the shared AND stage. It replaces per-requester free-running AND blocks.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `WIDTH`, 8, operand/result width in bits
- `ID_W`, `$clog2(N_REQ)` (min 1), requester ID width (derived, not overridden)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset (assert async, deassert sync to `clk` externally)
- `req_valid`  in  N_REQ  per-requester operand valid
- `req_a`  in  N_REQ×WIDTH  operand A per requester
- `req_b`  in  N_REQ×WIDTH  operand B per requester
- `req_ready`  out  N_REQ  one-hot (or zero) grant/accept
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  result consumer ready
- `rsp_id`  out  ID_W  ID of the requester whose result is presented
- `rsp_q`  out  WIDTH  registered `a & b`
- `op_count`  out  16  accepted-operation count, saturating at 16'hFFFF

## Operation
- FSM states are `IDLE` and `RESP`.
- **`IDLE` state:**
  - `rsp_valid` = 0.
  - If any `req_valid` is high, the round-robin winner `w` gets `req_ready[w]` = 1 in the same cycle (combinational from `req_valid` and the pointer).
  - On that edge: `rsp_q` <= `req_a[w] & req_b[w]`, `rsp_id` <= `w`, `last` <= `w`, `op_count`++. The FSM moves to `RESP`.
- **`RESP` state:**
  - `rsp_valid` = 1. `rsp_q` and `rsp_id` are held stable while `rsp_ready` = 0.
  - `req_ready` is all-zero unless `rsp_ready` = 1.
  - If `rsp_ready` = 1 and any `req_valid` is high: accept the new winner (same captures as in `IDLE`) and stay in `RESP`. This gives back-to-back throughput.
  - If `rsp_ready` = 1 and no `req_valid` is high: go to `IDLE`.
- **Round robin:**
  - Priority order starts at `last+1` modulo `N_REQ` and wraps.
  - A requester that was just granted has lowest priority next cycle.
  - Non-requesting inputs are skipped.
- A transfer occurs only on `req_valid[i] && req_ready[i]`. Operands of non-granted requesters are ignored.
- `op_count` increments once per accepted transfer. At 16'hFFFF it holds.
- **Reset values:**
  - FSM = `IDLE`, `rsp_valid` = 0, `rsp_q` = 0, `rsp_id` = 0, `op_count` = 0.
  - `last` = `N_REQ-1`, so requester 0 wins first.
  - `req_ready` = 0 while `rst_n` is low.
- **Reset mid-operation:** a pending unconsumed result is discarded immediately; no response is replayed after reset.

## Timing
- Latency is 1 cycle. Accept at edge *t* gives `rsp_valid` high with the result from *t* to *t+1*.
- Sustained throughput is 1 operation per cycle while `rsp_ready` = 1 and requests are present.
- Response stall: `req_ready` stays 0 for the whole stall, so no operand is lost or overwritten.
- All-requesters-active: each requester is granted once every `N_REQ` accepted cycles.
- Single requester continuously valid: it is granted every cycle. Fairness does not block it.
- `req_valid` dropping in the grant cycle produces no transfer, and `last` is unchanged.

## Structure
- **Package `and_arb_pkg`:** state enum `arb_state_t {IDLE, RESP}`, and the `op_count` width constant `CNT_W` = 16.
- **Sub-module `rr_arbiter`:**
  - Parameter `N`.
  - Inputs: `req[N]`, `last[ID_W]`, `en`.
  - Outputs: one-hot `gnt[N]`, `gnt_id`, `any`.
  - Purely combinational rotate-priority-rotate-back logic.
- **Top level:** FSM, `last` register, result/ID registers, saturating counter.

## Test plan
1. **Reset then single request:** after reset, `req_valid` = 2'b01, `a0` = 8'hF0, `b0` = 8'h3C, `rsp_ready` = 1. Expect `req_ready` = 2'b01, then next cycle `rsp_valid` = 1, `rsp_q` = 8'h30, `rsp_id` = 0, `op_count` = 1.
2. **Both requesting continuously:** `req_valid` = 2'b11, `rsp_ready` = 1 for 6 cycles. Expect grants 0,1,0,1,0,1, `rsp_id` following one cycle later, and `op_count` = 6.
3. **Backpressure:** accept requester 1 (`a` = 8'hAA, `b` = 8'hFF), then hold `rsp_ready` = 0 for 4 cycles with both valid. Expect `rsp_q` = 8'hAA and `rsp_id` = 1 held, `req_ready` = 0 throughout. On release, requester 0 is granted next.
4. **Reset mid-response:** assert `rst_n` = 0 while `rsp_valid` = 1. Expect `rsp_valid`, `rsp_q` and `op_count` to go to 0 asynchronously. After release, requester 0 wins first.
5. **Counter saturation:** force `op_count` to 16'hFFFE, then do 3 accepts. Expect 16'hFFFF and held there.
6. **`N_REQ` = 4 sparse requests:** `req_valid` = 4'b1010 with `last` = 1. Expect grant 3, then 1, then 3. Idle requesters are never granted.
